// File: rtl/frame_cfg_pkg.sv
// Shared types and defaults for the configuration-frame sequencer.
// The optional parity check on incoming words is enabled by defining CFG_PARITY_EN.
package frame_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int DEF_FRAME_BITS = 32;
  localparam int DEF_FRAMES     = 20;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  // The down-counter only ever holds (window - 1), so clog2 of the widest window suffices.
  function automatic int cnt_width(input int setup_cyc, input int strobe_cyc, input int hold_cyc);
    int m;
    m = setup_cyc;
    if (strobe_cyc > m) begin
      m = strobe_cyc;
    end
    if (hold_cyc > m) begin
      m = hold_cyc;
    end
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/frame_strobe_dec.sv
// Registered one-hot decoder for the latch-column enables; outputs come
// straight from flops so the strobes cannot glitch.
module frame_strobe_dec #(
  parameter int FRAMES = 20,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [FRAMES-1:0] strobe_o
);

  logic [FRAMES-1:0] dec_s;
  logic [FRAMES-1:0] strobe_q;

  // Addresses outside the column range decode to all-zero.
  always_comb begin
    dec_s = '0;
    for (int i = 0; i < FRAMES; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        dec_s[i] = 1'b1;
      end else begin
        dec_s[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strobe_q <= '0;
    end else if (clr_i) begin
      strobe_q <= '0;
    end else if (set_i) begin
      strobe_q <= dec_s;
    end else begin
      strobe_q <= strobe_q;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_config_ctrl.sv
// Sequences addressed frame words into latch columns with setup/strobe/hold windows.
// Define CFG_PARITY_EN to add the in_parity port and even-parity rejection.
module frame_config_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int FRAMES     = DEF_FRAMES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [FRAME_BITS-1:0] in_data,
`ifdef CFG_PARITY_EN
  input  logic                  in_parity,
`endif
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [FRAMES-1:0]     frame_strobe,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  err
);

  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [FRAMES-1:0]     written_q, written_d;
  logic                  err_q, err_d;
  logic                  ready_q, busy_q, done_q;
  logic                  accept_s, bad_s, strobe_set_s, strobe_clr_s;

  assign accept_s = in_valid & ready_q;

  // Reject out-of-range addresses (and, optionally, bad parity) without starting a sequence.
  always_comb begin
    bad_s = ({1'b0, in_addr} >= (ADDR_W + 1)'(FRAMES));
`ifdef CFG_PARITY_EN
    if (^{in_data, in_parity}) begin
      bad_s = 1'b1;
    end else begin
      bad_s = bad_s;
    end
`endif
  end

  // Next-state and datapath updates for the setup/strobe/hold sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    written_d    = written_q;
    err_d        = err_q;
    strobe_set_s = 1'b0;
    strobe_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && bad_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          data_d  = in_data;
          addr_d  = in_addr;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          strobe_set_s = 1'b1;
          cnt_d        = CNT_W'(STROBE_CYC - 1);
          state_d      = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          strobe_clr_s = 1'b1;
          cnt_d        = CNT_W'(HOLD_CYC - 1);
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          for (int i = 0; i < FRAMES; i++) begin
            if (addr_q == ADDR_W'(i)) begin
              written_d[i] = 1'b1;
            end else begin
              written_d[i] = written_q[i];
            end
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake/status flags are registered from next-state so they align with the state flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      written_q <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      written_q <= written_d;
      err_q     <= err_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= &written_d;
    end
  end

  frame_strobe_dec #(
    .FRAMES (FRAMES),
    .ADDR_W (ADDR_W)
  ) u_strobe_dec (
    .clk_i    (CLK),
    .rst_i    (RST),
    .set_i    (strobe_set_s),
    .clr_i    (strobe_clr_s),
    .addr_i   (addr_q),
    .strobe_o (frame_strobe)
  );

  assign frame_data = data_q;
  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign cfg_done   = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Directed bench for frame_config_ctrl: a queue of expected strobes/data is
// consumed by an independent monitor; timing and status are checked inline.
module tb_frame_config_ctrl;

  localparam int FB = 32;
  localparam int NF = 20;
  localparam int AW = 5;
  localparam int STROBE_LEN = 2;
`ifdef CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NF-1:0] stb;
    logic [FB-1:0] data;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [FB-1:0] in_data = '0;
`ifdef CFG_PARITY_EN
  logic          in_parity = 1'b0;
`endif
  logic [FB-1:0] frame_data;
  logic [NF-1:0] frame_strobe;
  logic          busy, cfg_done, err;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  frame_config_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
`ifdef CFG_PARITY_EN
    .in_parity    (in_parity),
`endif
    .frame_data   (frame_data),
    .frame_strobe (frame_strobe),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .err          (err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Offer a word at a negedge; returns at the negedge after the acceptance edge T.
  task automatic send(input logic [AW-1:0] a, input logic [FB-1:0] d, input logic p,
                      output int t_acc, output int waited);
    exp_t e;
    logic bad;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
`ifdef CFG_PARITY_EN
    in_parity = p;
`endif
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 50) begin
      chk("handshake_timeout", 64'(waited), 64'd0);
    end
    t_acc = cyc + 1;
    bad = (a >= AW'(NF)) || (PAR_EN && (^{d, p}));
    if (!bad) begin
      e.stb  = NF'(1) << a;
      e.data = d;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Monitor: every strobe rise must match the next expected frame; strobes stay one-hot,
  // stable, last STROBE_LEN cycles, and frame_data must not move underneath them.
  initial begin
    logic [NF-1:0] prev;
    logic [FB-1:0] cap;
    int            hi;
    exp_t          e;
    prev = '0;
    cap  = '0;
    hi   = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev = '0;
        hi   = 0;
      end else begin
        if (prev == '0 && frame_strobe != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 64'(frame_strobe), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_line", 64'(frame_strobe), 64'(e.stb));
            chk("strobe_data", 64'(frame_data), 64'(e.data));
          end
          cap = frame_data;
        end
        if (frame_strobe != '0) begin
          hi++;
          chk("strobe_onehot", 64'($onehot(frame_strobe)), 64'd1);
          chk("data_stable_under_strobe", 64'(frame_data), 64'(cap));
          if (prev != '0) begin
            chk("strobe_stable", 64'(frame_strobe), 64'(prev));
          end
        end else if (prev != '0) begin
          chk("strobe_width", 64'(hi), 64'(STROBE_LEN));
          hi = 0;
        end
        prev = frame_strobe;
      end
    end
  end

  initial begin
    int t, t2, w;
    // Reset state
    tick(2);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_frame_data", 64'(frame_data), 64'd0);
    chk("rst_strobe", 64'(frame_strobe), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cfg_done", 64'(cfg_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    RST = 1'b0;
    tick(1);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Single write, cycle-exact timing
    send(5'd3, 32'hA5A5_0F0F, ^32'hA5A5_0F0F, t, w);
    chk("t_data", 64'(frame_data), 64'hA5A5_0F0F);
    chk("t_strobe_setup", 64'(frame_strobe), 64'd0);
    chk("t_busy", 64'(busy), 64'd1);
    chk("t_ready", 64'(in_ready), 64'd0);
    tick(1);
    chk("t1_strobe", 64'(frame_strobe), 64'h8);
    tick(1);
    chk("t2_strobe", 64'(frame_strobe), 64'h8);
    tick(1);
    chk("t3_strobe", 64'(frame_strobe), 64'd0);
    chk("t3_data_hold", 64'(frame_data), 64'hA5A5_0F0F);
    chk("t3_ready", 64'(in_ready), 64'd0);
    tick(1);
    chk("t4_ready", 64'(in_ready), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);

    // Back-to-back, valid held
    send(5'd0, 32'h1111_2222, ^32'h1111_2222, t, w);
    send(5'd1, 32'h3333_4444, ^32'h3333_4444, t2, w);
    chk("b2b_spacing", 64'(t2 - t), 64'd5);
    tick(4);

    // Out-of-range address
    send(5'd25, 32'hDEAD_BEEF, ^32'hDEAD_BEEF, t, w);
    chk("badaddr_wait", 64'(w), 64'd0);
    chk("badaddr_err", 64'(err), 64'd1);
    chk("badaddr_ready", 64'(in_ready), 64'd1);
    chk("badaddr_busy", 64'(busy), 64'd0);
    tick(3);
    chk("badaddr_no_strobe", 64'(frame_strobe), 64'd0);
    chk("badaddr_err_sticky", 64'(err), 64'd1);

    // Reset during STROBE of frame 7
    send(5'd7, 32'h7777_0007, ^32'h7777_0007, t, w);
    tick(1);
    chk("r7_strobe_high", 64'(frame_strobe), 64'h80);
    RST = 1'b1;
    #1;
    chk("r7_strobe_async", 64'(frame_strobe), 64'd0);
    chk("r7_data", 64'(frame_data), 64'd0);
    chk("r7_ready", 64'(in_ready), 64'd0);
    chk("r7_busy", 64'(busy), 64'd0);
    chk("r7_err", 64'(err), 64'd0);
    tick(2);
    RST = 1'b0;
    tick(1);

    // Load every frame except 7 in descending order
    for (int a = NF - 1; a >= 0; a--) begin
      if (a != 7) begin
        send(AW'(a), 32'hC0DE_0000 | 32'(a), ^(32'hC0DE_0000 | 32'(a)), t, w);
      end
    end
    tick(4);
    chk("done_missing_7", 64'(cfg_done), 64'd0);

    // Frame 7 completes the set; cfg_done rises on its HOLD exit
    send(5'd7, 32'h0000_0707, ^32'h0000_0707, t, w);
    tick(3);
    chk("done_before_hold_exit", 64'(cfg_done), 64'd0);
    tick(1);
    chk("done_after_hold_exit", 64'(cfg_done), 64'd1);

    // Rewrite frame 5
    send(5'd5, 32'h5555_AAAA, ^32'h5555_AAAA, t, w);
    chk("rewrite_done_kept", 64'(cfg_done), 64'd1);
    tick(4);
    chk("rewrite_done_after", 64'(cfg_done), 64'd1);

`ifdef CFG_PARITY_EN
    send(5'd2, 32'h0000_0001, 1'b0, t, w);
    chk("par_bad_err", 64'(err), 64'd1);
    chk("par_bad_ready", 64'(in_ready), 64'd1);
    tick(3);
    send(5'd2, 32'h0000_0001, 1'b1, t, w);
    tick(1);
    chk("par_good_strobe", 64'(frame_strobe), 64'h4);
    tick(3);
    chk("par_err_sticky", 64'(err), 64'd1);
`else
    chk("err_clear_no_parity", 64'(err), 64'd0);
`endif

    tick(2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_config_ctrl.md
# frame_config_ctrl

Sequences configuration frames into the fabric's latch-based configuration memory. The latches (D/E, level-sensitive) drive the select inputs of the 4:1 and 16:1 routing muxes. The block accepts addressed frame words over a valid/ready handshake and drives the shared frame-data bus. It then issues a glitch-free, one-hot frame strobe to the addressed latch column, with programmable setup, pulse and hold windows. It sits between the bitstream source and the tile array and tracks which frames have been written.

## Interface
- FRAME_BITS, 32, width of one configuration frame (latch count per column)
- FRAMES, 20, number of frame strobe lines (latch columns)
- ADDR_W, 5, frame address width; must satisfy 2**ADDR_W >= FRAMES
- SETUP_CYC, 1, cycles frame_data is stable before strobe rises (>=1)
- STROBE_CYC, 2, cycles strobe is high (>=1)
- HOLD_CYC, 1, cycles frame_data is held after strobe falls (>=1)

Ports:
- CLK  in  1  fabric configuration clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  frame word offered
- in_ready  out  1  controller can accept a word
- in_addr  in  ADDR_W  target frame index
- in_data  in  FRAME_BITS  frame contents
- in_parity  in  1  even parity over in_data; present only with CFG_PARITY_EN
- frame_data  out  FRAME_BITS  shared latch D bus, registered
- frame_strobe  out  FRAMES  latch E lines, one-hot or zero, registered
- busy  out  1  sequence in progress
- cfg_done  out  1  every frame index 0..FRAMES-1 written at least once
- err  out  1  sticky error flag

## Operation
- States: IDLE, SETUP, STROBE, HOLD. Down-counter cnt, wide enough for max(SETUP_CYC, STROBE_CYC, HOLD_CYC).
- IDLE: in_ready=1. On in_valid with a valid address, frame_data<=in_data, latch addr, cnt<=SETUP_CYC-1, go to SETUP.
- Address >= FRAMES: word is consumed (handshake completes), err<=1, no strobe, stay IDLE.
- SETUP: strobe all zero; when cnt==0, frame_strobe[addr]<=1, cnt<=STROBE_CYC-1, go to STROBE.
- STROBE: strobe held; when cnt==0, strobe<=0, cnt<=HOLD_CYC-1, go to HOLD.
- HOLD: frame_data unchanged; when cnt==0, written[addr]<=1, go to IDLE.
- frame_data changes only on acceptance and never while any strobe is high.
- frame_strobe is driven straight from flops, with no combinational decode on the output path. It is never multi-hot.
- busy = (state != IDLE). in_ready = (state == IDLE).
- written bitmap (FRAMES bits) is cleared only by RST. cfg_done = &written. A rewritten frame re-strobes normally and cfg_done stays 1.
- err is sticky until RST.

## Timing
- Reset values: frame_data=0, frame_strobe=0, in_ready=0 while RST is asserted and 1 from the first clock edge after release. busy=0, cfg_done=0, err=0, state=IDLE.
- RST mid-sequence: strobe drops asynchronously, and the partly written frame is not marked written.
- Acceptance edge T. Strobe rises at T+SETUP_CYC, falls at T+SETUP_CYC+STROBE_CYC, and the block returns to IDLE at T+SETUP_CYC+STROBE_CYC+HOLD_CYC.
- in_ready is high in the cycle after the final HOLD cycle.
- Throughput: one frame per 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles. Defaults give 5.
- Consumer-side rule: in_valid may be held across busy periods; in_addr and in_data must stay stable while in_valid=1 and in_ready=0.
- cfg_done rises on the edge that leaves HOLD for the last unwritten frame.

## Configuration
- CFG_PARITY_EN defined:
  - in_parity port exists.
  - On acceptance, if ^{in_data,in_parity} != 0, the word is consumed, err<=1, and no sequence runs.
  - This check is applied together with the address check.
- CFG_PARITY_EN undefined: no in_parity port, no check, err is set only by a bad address.

## Structure
- Package frame_cfg_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD);
  - default parameter constants;
  - a function computing counter width from the three cycle parameters.
- One sub-module, frame_strobe_dec: registered one-hot decoder with enable and async clear. It produces frame_strobe from the latched address.

## Test plan
- Defaults; write addr 3, data 0xA5A5_0F0F:
  - frame_data = 0xA5A5_0F0F from T+1;
  - frame_strobe = 1<<3 during cycles T+1..T+2 only (strobe rises at T+1, falls at T+3);
  - in_ready = 1 again at T+4.
- Back-to-back valid words to addrs 0,1 held on the bus: second acceptance occurs exactly 5 cycles after the first. Strobes never overlap, and frame_data never changes while a strobe is high.
- Write addr 25 (>= FRAMES): handshake completes in 1 cycle, err=1, frame_strobe stays 0, written is unchanged.
- Write all 20 frames in order 19..0: cfg_done=0 until the HOLD exit of frame 0, then 1. Rewriting frame 5 keeps cfg_done=1.
- Assert RST during STROBE of addr 7: frame_strobe goes to 0 immediately and all outputs take their reset values. A later full load still needs frame 7 before cfg_done=1.
- With CFG_PARITY_EN, send data 0x0000_0001 with in_parity=0: err=1 and no strobe. With in_parity=1, the frame is written normally.
